// File: rtl/sfx_sequencer_if.sv
// Event/tone bundle between the game logic (master) and the sound-effect
// sequencer (slave).
interface sfx_sequencer_if #(
  parameter int HP_W = 18
);
  logic            evt_hit;
  logic            evt_score;
  logic            evt_over;
  logic            mute;
  logic [HP_W-1:0] bgm_hp;
  logic [HP_W-1:0] half_period;
  logic            sfx_busy;
  logic [1:0]      sfx_id;
  logic            sfx_done;

  modport master (
    output evt_hit, evt_score, evt_over, mute, bgm_hp,
    input  half_period, sfx_busy, sfx_id, sfx_done
  );

  modport slave (
    input  evt_hit, evt_score, evt_over, mute, bgm_hp,
    output half_period, sfx_busy, sfx_id, sfx_done
  );
endinterface

// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: turns game-event pulses into ROM note sequences for
// the buzzer tone stage. Optional feature macro: SFX_PREEMPT_EN (higher-priority effects abort).
module sfx_sequencer #(
  parameter int HP_W     = 18,
  parameter int STEP_CYC = 5_000_000
) (
  input logic             clk,
  input logic             rst_n,
  sfx_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(STEP_CYC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_END
  } state_t;

  state_t          state;
  logic [2:0]      pending;
  logic [CNT_W-1:0] step_cnt;
  logic [2:0]      note_idx;
  logic [HP_W-1:0] half_period_q;
  logic            busy_q;
  logic [1:0]      id_q;
  logic            done_q;

  logic [2:0]      evt_set;
  logic [2:0]      pend_all;
  logic [1:0]      sel_id;
  logic [2:0]      sel_mask;
  logic            start;
  logic [2:0]      start_mask;
  logic [2:0]      pending_next;

  // Effect id doubles as priority: over(3) > score(2) > hit(1).
  function automatic logic [HP_W-1:0] rom_note(input logic [1:0] id, input logic [2:0] idx);
    logic [HP_W-1:0] v;
    case ({id, idx})
      5'b01_000: v = HP_W'(42553);
      5'b01_001: v = HP_W'(63776);
      5'b10_000: v = HP_W'(63776);
      5'b10_001: v = HP_W'(50607);
      5'b10_010: v = HP_W'(42553);
      5'b10_011: v = HP_W'(42553);
      5'b11_000: v = HP_W'(42553);
      5'b11_001: v = HP_W'(47778);
      5'b11_010: v = HP_W'(50607);
      5'b11_011: v = HP_W'(56818);
      5'b11_100: v = HP_W'(63776);
      5'b11_101: v = HP_W'(85136);
      default:   v = '0;
    endcase
    return v;
  endfunction

  function automatic logic [2:0] last_idx(input logic [1:0] id);
    logic [2:0] v;
    case (id)
      2'd1:    v = 3'd1;
      2'd2:    v = 3'd3;
      2'd3:    v = 3'd5;
      default: v = 3'd0;
    endcase
    return v;
  endfunction

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    evt_set  = {bus.evt_over, bus.evt_score, bus.evt_hit};
    pend_all = pending | evt_set;
    sel_id   = 2'd0;
    sel_mask = 3'b000;
    if (pend_all[2]) begin
      sel_id = 2'd3; sel_mask = 3'b100;
    end else if (pend_all[1]) begin
      sel_id = 2'd2; sel_mask = 3'b010;
    end else if (pend_all[0]) begin
      sel_id = 2'd1; sel_mask = 3'b001;
    end

    start = 1'b0;
    case (state)
      S_IDLE, S_END: start = |pend_all;
`ifdef SFX_PREEMPT_EN
      S_PLAY:        start = (sel_id > id_q);
`else
      S_PLAY:        start = 1'b0;
`endif
      default:       start = 1'b0;
    endcase
    start_mask = start ? sel_mask : 3'b000;

    // A starting bit stays set only if it was already queued and re-pulsed now.
    pending_next = (pend_all & ~start_mask) | (evt_set & pending & start_mask);
  end

  // NOTE: sequential state uses non-blocking assignments; all registers,
  // including the pending queue, are cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pending       <= 3'b000;
      step_cnt      <= '0;
      note_idx      <= 3'd0;
      half_period_q <= '0;
      busy_q        <= 1'b0;
      id_q          <= 2'd0;
      done_q        <= 1'b0;
    end else begin
      pending <= pending_next;
      done_q  <= 1'b0;
      if (start) begin
        state         <= S_PLAY;
        id_q          <= sel_id;
        busy_q        <= 1'b1;
        step_cnt      <= '0;
        note_idx      <= 3'd0;
        half_period_q <= bus.mute ? '0 : rom_note(sel_id, 3'd0);
      end else begin
        case (state)
          S_IDLE: half_period_q <= bus.mute ? '0 : bus.bgm_hp;
          S_PLAY: begin
            if (step_cnt == CNT_W'(STEP_CYC - 1)) begin
              step_cnt <= '0;
              if (note_idx == last_idx(id_q)) begin
                state         <= S_END;
                busy_q        <= 1'b0;
                id_q          <= 2'd0;
                done_q        <= 1'b1;
                note_idx      <= 3'd0;
                half_period_q <= '0;
              end else begin
                note_idx      <= note_idx + 3'd1;
                half_period_q <= bus.mute ? '0 : rom_note(id_q, note_idx + 3'd1);
              end
            end else begin
              step_cnt      <= step_cnt + CNT_W'(1);
              half_period_q <= bus.mute ? '0 : rom_note(id_q, note_idx);
            end
          end
          S_END: begin
            state         <= S_IDLE;
            half_period_q <= bus.mute ? '0 : bus.bgm_hp;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.half_period = half_period_q;
  assign bus.sfx_busy    = busy_q;
  assign bus.sfx_id      = id_q;
  assign bus.sfx_done    = done_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Scoreboard bench for sfx_sequencer: stimulus queues one expected output
// record per cycle, a negedge monitor pops and compares.
module tb_sfx_sequencer;
  localparam int HP_W = 18;
  localparam int STEP = 10;
  localparam int BGM  = 37936;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  sfx_sequencer_if #(.HP_W(HP_W)) bus ();

  sfx_sequencer #(.HP_W(HP_W), .STEP_CYC(STEP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          test_no;
    int          cyc;
    logic [31:0] hp;
    logic        busy;
    logic [1:0]  id;
    logic        done;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cur_test = 0;
  int   push_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Spec note tables.
  function automatic int exp_note(input int id, input int idx);
    int hit_t[2]   = '{42553, 63776};
    int score_t[4] = '{63776, 50607, 42553, 42553};
    int over_t[6]  = '{42553, 47778, 50607, 56818, 63776, 85136};
    case (id)
      1:       return hit_t[idx];
      2:       return score_t[idx];
      3:       return over_t[idx];
      default: return 0;
    endcase
  endfunction

  task automatic push(input int hp, input bit busy, input int id, input bit done);
    exp_t e;
    e.test_no = cur_test;
    e.cyc     = push_cyc;
    e.hp      = hp;
    e.busy    = busy;
    e.id      = 2'(id);
    e.done    = done;
    exp_q.push_back(e);
    push_cyc++;
  endtask

  task automatic push_idle(input int hp, input int n);
    for (int i = 0; i < n; i++) push(hp, 1'b0, 0, 1'b0);
  endtask

  task automatic push_play(input int id, input int n_notes, input int first_len, input bit muted);
    for (int k = 0; k < n_notes; k++)
      for (int s = 0; s < ((k == 0) ? first_len : STEP); s++)
        push(muted ? 0 : exp_note(id, k), 1'b1, id, 1'b0);
  endtask

  task automatic push_end();
    push(0, 1'b0, 0, 1'b1);
  endtask

  task automatic begin_test(input int n);
    cur_test = n;
    push_cyc = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  // Monitor: one expected record per cycle while the queue holds entries.
  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check($sformatf("t%0d_c%0d_half_period", mon_e.test_no, mon_e.cyc), 32'(bus.half_period), mon_e.hp);
      check($sformatf("t%0d_c%0d_sfx_busy", mon_e.test_no, mon_e.cyc), 32'(bus.sfx_busy), 32'(mon_e.busy));
      check($sformatf("t%0d_c%0d_sfx_id", mon_e.test_no, mon_e.cyc), 32'(bus.sfx_id), 32'(mon_e.id));
      check($sformatf("t%0d_c%0d_sfx_done", mon_e.test_no, mon_e.cyc), 32'(bus.sfx_done), 32'(mon_e.done));
    end
  end

  initial begin
    bus.evt_hit   = 1'b0;
    bus.evt_score = 1'b0;
    bus.evt_over  = 1'b0;
    bus.mute      = 1'b0;
    bus.bgm_hp    = '0;

    // Reset state, then two idle cycles with bgm_hp=0.
    begin_test(0);
    tick();
    tick();
    push_idle(0, 1);
    tick();
    rst_n = 1'b1;
    push_idle(0, 2);
    run(2);

    // 1: passthrough and mute.
    begin_test(1);
    bus.bgm_hp = HP_W'(BGM);
    push_idle(0, 1);
    push_idle(BGM, 1);
    push_idle(0, 1);
    push_idle(BGM, 1);
    tick();
    bus.mute = 1'b1;
    tick();
    bus.mute = 1'b0;
    run(2);

    // 2: single hit effect.
    begin_test(2);
    push_idle(BGM, 1);
    push_play(1, 2, STEP, 1'b0);
    push_end();
    push_idle(BGM, 1);
    bus.evt_hit = 1'b1;
    tick();
    bus.evt_hit = 1'b0;
    run(22);

    // 3: simultaneous hit and over; over wins, hit follows.
    begin_test(3);
    push_idle(BGM, 1);
    push_play(3, 6, STEP, 1'b0);
    push_end();
    push_play(1, 2, STEP, 1'b0);
    push_end();
    push_idle(BGM, 1);
    bus.evt_hit  = 1'b1;
    bus.evt_over = 1'b1;
    tick();
    bus.evt_hit  = 1'b0;
    bus.evt_over = 1'b0;
    run(83);

    // 4: over arrives while hit is playing.
    begin_test(4);
    push_idle(BGM, 1);
`ifdef SFX_PREEMPT_EN
    push_play(1, 1, 5, 1'b0);
    push_play(3, 6, STEP, 1'b0);
    push_end();
    push_idle(BGM, 1);
`else
    push_play(1, 2, STEP, 1'b0);
    push_end();
    push_play(3, 6, STEP, 1'b0);
    push_end();
    push_idle(BGM, 1);
`endif
    bus.evt_hit = 1'b1;
    tick();
    bus.evt_hit = 1'b0;
    run(4);
    bus.evt_over = 1'b1;
    tick();
    bus.evt_over = 1'b0;
`ifdef SFX_PREEMPT_EN
    run(62);
`else
    run(78);
`endif

    // 7: queued hit re-pulsed on the END cycle that starts it -> plays twice.
    begin_test(7);
    push_idle(BGM, 1);
    push_play(3, 6, STEP, 1'b0);
    push_end();
    push_play(1, 2, STEP, 1'b0);
    push_end();
    push_play(1, 2, STEP, 1'b0);
    push_end();
    push_idle(BGM, 1);
    bus.evt_over = 1'b1;
    tick();
    bus.evt_over = 1'b0;
    run(2);
    bus.evt_hit = 1'b1;
    tick();
    bus.evt_hit = 1'b0;
    run(57);
    bus.evt_hit = 1'b1;
    tick();
    bus.evt_hit = 1'b0;
    run(43);

    // 5: reset in the middle of a score effect.
    begin_test(5);
    push_idle(BGM, 1);
    push_play(2, 2, STEP, 1'b0);
    for (int i = 0; i < 6; i++) push_cyc--;  // trim the second note to 4 cycles
    for (int i = 0; i < 6; i++) void'(exp_q.pop_back());
    push_idle(0, 3);
    push_idle(0, 8);
    bus.evt_score = 1'b1;
    tick();
    bus.evt_score = 1'b0;
    run(14);
    rst_n      = 1'b0;
    bus.bgm_hp = '0;
    run(2);
    rst_n = 1'b1;
    run(9);

    // 6: muted score effect.
    begin_test(6);
    push_idle(0, 1);
    push_play(2, 4, STEP, 1'b1);
    push_end();
    push_idle(0, 1);
    bus.bgm_hp    = HP_W'(BGM);
    bus.mute      = 1'b1;
    bus.evt_score = 1'b1;
    tick();
    bus.evt_score = 1'b0;
    run(42);
    bus.mute = 1'b0;

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
